anabellek_hakem: RTL
====================

Name: anabellek_hakem

Overview:
- Arbitrates the single main-memory controller between the instruction cache (bb_*, read-only) and the data cache (vb_*, read/write).
- Sits between the two cache controllers and the main-memory controller.
- Latches one 128-bit block request, drives the controller's request interface, waits for it to finish, then returns completion and read data to the winner.
- Only one transaction is outstanding at a time.

Parameters:
- ADRES_BIT, 32, address width.
- OBEK_BIT, 128, block width (4 x 32-bit words).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- bb_istek_i  in  1  instruction-cache block read request; held until bb_kabul_o.
- bb_adres_i  in  ADRES_BIT  instruction-cache block address.
- vb_istek_i  in  1  data-cache request; held until vb_kabul_o.
- vb_yaz_i  in  1  data-cache op: 1 = write block, 0 = read block.
- vb_adres_i  in  ADRES_BIT  data-cache block address.
- vb_yaz_obek_i  in  OBEK_BIT  data-cache write block.
- bb_kabul_o  out  1  1-cycle pulse: instruction request latched.
- bb_bitti_o  out  1  1-cycle pulse: instruction read done, okunan_obek_o valid.
- vb_kabul_o  out  1  1-cycle pulse: data request latched.
- vb_bitti_o  out  1  1-cycle pulse: data transaction done; okunan_obek_o valid if read.
- okunan_obek_o  out  OBEK_BIT  last read block, registered, held until next read completes.
- anabellege_istek_o  out  1  request to memory controller.
- oku_o  out  1  read select to controller.
- yaz_o  out  1  write select to controller.
- oku_adres_o  out  ADRES_BIT  read address to controller.
- yaz_adres_o  out  ADRES_BIT  write address to controller.
- yaz_veri_obegi_o  out  OBEK_BIT  write block to controller.
- anabellek_musait_i  in  1  controller idle.
- okunan_veri_obegi_i  in  OBEK_BIT  controller read block.

Behaviour:
- All outputs registered.
- Reset (rst_i=1 at posedge) sets state BOS and clears all outputs and latched registers to 0.
- Reset mid-transaction aborts: the arbiter drops anabellege_istek_o and gives no bitti pulse. The controller is reset by the same reset.
- Latched request registers: sahip (0 = bb, 1 = vb), yaz, adres, obek.
  - Addresses are driven with bits [3:0] forced to 0.
  - oku_adres_o and yaz_adres_o both carry the latched address.
  - oku_o = ~yaz, yaz_o = yaz; both are valid for the whole transaction.
  - yaz_veri_obegi_o holds the latched block, stable from GONDER until BOS.
- State BOS:
  - If anabellek_musait_i=1 and any istek_i=1: select the winner, latch its fields, pulse its kabul_o next cycle, go GONDER.
  - If musait=0 (including the first cycle after reset): no grant.
- Priority: fixed, vb wins when both request in the same cycle.
- State GONDER: anabellege_istek_o=1 for exactly one cycle; go BEKLE.
- State BEKLE: istek_o=0; wait for anabellek_musait_i=0, then go MESGUL.
- State MESGUL: wait for anabellek_musait_i=1. On that cycle:
  - If read, capture okunan_veri_obegi_i into okunan_obek_o.
  - Go TAMAM.
- State TAMAM: pulse the owner's bitti_o for one cycle; go BOS.
- A new grant is possible on the cycle after TAMAM.
- Latency, grant to bitti: kabul at cycle k+1; istek_o at k+1; bitti = 3 + controller busy cycles after k+1.
- A requester deasserting istek before kabul is treated as withdrawn.
- istek while not in BOS is ignored (no kabul).
- A new request from the same requester is accepted only after its bitti.

Optional Feature:
- Macro: ANABELLEK_HAKEM_ADIL_EN.
- Defined: round-robin. A 1-bit son_sahip register (reset 0) records the last winner; on a simultaneous request the other requester wins. A lone requester always wins.
- Undefined: fixed vb priority; son_sahip register absent.

Test Plan:
- Reset then bb read 0x0000_1004 with controller model (musait low 6 cycles):
  - oku_adres_o=0x0000_1000, oku_o=1, istek_o single-cycle pulse.
  - Returned block 0x11111111_22222222_33333333_44444444 appears on okunan_obek_o with bb_bitti_o pulse; vb_bitti_o stays 0.
- vb write 0x0000_2000, block 0xAAAA..., vb_yaz_i=1:
  - yaz_o=1, yaz_adres_o=0x0000_2000.
  - yaz_veri_obegi_o stable through MESGUL.
  - vb_bitti_o pulses; okunan_obek_o unchanged from prior read.
- bb and vb request in the same cycle, each held until kabul:
  - Macro off: vb served first, then bb; exactly two kabul and two bitti pulses.
  - Macro on, preceded by a vb transaction: bb served first.
- Request while anabellek_musait_i=0 (cycle after reset): no kabul until musait=1.
- rst_i=1 during MESGUL:
  - Next cycle all outputs 0, state BOS, no bitti pulse.
  - A fresh bb request afterwards completes normally.
- Back-to-back vb reads to 0x100 and 0x110: second kabul no earlier than the cycle after the first vb_bitti_o; both blocks returned in order.

Source files
------------

// File: rtl/anabellek_hakem.sv
// anabellek_hakem: arbitrates one main-memory controller between instruction cache (bb) and data cache (vb).
// Optional ANABELLEK_HAKEM_ADIL_EN selects round-robin on simultaneous requests instead of fixed vb priority.
module anabellek_hakem #(
    parameter int ADRES_BIT = 32,
    parameter int OBEK_BIT  = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bb_istek_i,
    input  logic [ADRES_BIT-1:0] bb_adres_i,
    input  logic                 vb_istek_i,
    input  logic                 vb_yaz_i,
    input  logic [ADRES_BIT-1:0] vb_adres_i,
    input  logic [OBEK_BIT-1:0]  vb_yaz_obek_i,
    output logic                 bb_kabul_o,
    output logic                 bb_bitti_o,
    output logic                 vb_kabul_o,
    output logic                 vb_bitti_o,
    output logic [OBEK_BIT-1:0]  okunan_obek_o,
    output logic                 anabellege_istek_o,
    output logic                 oku_o,
    output logic                 yaz_o,
    output logic [ADRES_BIT-1:0] oku_adres_o,
    output logic [ADRES_BIT-1:0] yaz_adres_o,
    output logic [OBEK_BIT-1:0]  yaz_veri_obegi_o,
    input  logic                 anabellek_musait_i,
    input  logic [OBEK_BIT-1:0]  okunan_veri_obegi_i
);

    // state  | meaning
    // BOS    | idle, grant when controller free and a request is present
    // GONDER | request pulse to controller
    // BEKLE  | wait for controller to go busy
    // MESGUL | wait for controller to finish, capture read block
    // TAMAM  | signal completion to the owner
    localparam logic [2:0] BOS    = 3'd0;
    localparam logic [2:0] GONDER = 3'd1;
    localparam logic [2:0] BEKLE  = 3'd2;
    localparam logic [2:0] MESGUL = 3'd3;
    localparam logic [2:0] TAMAM  = 3'd4;

    logic [2:0]           r_durum;
    logic                 r_sahip;
    logic                 r_yaz;
    logic                 r_oku;
    logic [ADRES_BIT-1:0] r_adres;
    logic [OBEK_BIT-1:0]  r_obek;
    logic [OBEK_BIT-1:0]  r_okunan;
    logic                 r_istek;
    logic                 r_bb_kabul;
    logic                 r_vb_kabul;
    logic                 r_bb_bitti;
    logic                 r_vb_bitti;

    logic                 w_kazanan;
    logic                 w_verilir;
    logic                 w_kazanan_yaz;
    logic [ADRES_BIT-1:0] w_bb_adres;
    logic [ADRES_BIT-1:0] w_vb_adres;

    assign w_bb_adres    = {bb_adres_i[ADRES_BIT-1:4], 4'b0000};
    assign w_vb_adres    = {vb_adres_i[ADRES_BIT-1:4], 4'b0000};
    assign w_verilir     = (r_durum == BOS) && anabellek_musait_i && (bb_istek_i || vb_istek_i);
    assign w_kazanan_yaz = w_kazanan && vb_yaz_i;

`ifdef ANABELLEK_HAKEM_ADIL_EN
    logic r_son_sahip;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        w_kazanan = vb_istek_i;
        if (bb_istek_i && vb_istek_i) begin
            w_kazanan = ~r_son_sahip;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_son_sahip <= 1'b0;
        end else if (w_verilir) begin
            r_son_sahip <= w_kazanan;
        end
    end
`else
    always_comb begin
        w_kazanan = vb_istek_i;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum    <= BOS;
            r_sahip    <= 1'b0;
            r_yaz      <= 1'b0;
            r_oku      <= 1'b0;
            r_adres    <= '0;
            r_obek     <= '0;
            r_okunan   <= '0;
            r_istek    <= 1'b0;
            r_bb_kabul <= 1'b0;
            r_vb_kabul <= 1'b0;
            r_bb_bitti <= 1'b0;
            r_vb_bitti <= 1'b0;
        end else begin
            r_istek    <= 1'b0;
            r_bb_kabul <= 1'b0;
            r_vb_kabul <= 1'b0;
            r_bb_bitti <= 1'b0;
            r_vb_bitti <= 1'b0;
            case (r_durum)
                BOS: begin
                    if (w_verilir) begin
                        r_sahip    <= w_kazanan;
                        r_yaz      <= w_kazanan_yaz;
                        r_oku      <= ~w_kazanan_yaz;
                        r_adres    <= w_kazanan ? w_vb_adres : w_bb_adres;
                        r_obek     <= w_kazanan ? vb_yaz_obek_i : '0;
                        r_bb_kabul <= ~w_kazanan;
                        r_vb_kabul <= w_kazanan;
                        r_istek    <= 1'b1;
                        r_durum    <= GONDER;
                    end
                end
                GONDER: begin
                    r_durum <= BEKLE;
                end
                BEKLE: begin
                    if (!anabellek_musait_i) begin
                        r_durum <= MESGUL;
                    end
                end
                MESGUL: begin
                    if (anabellek_musait_i) begin
                        if (!r_yaz) begin
                            r_okunan <= okunan_veri_obegi_i;
                        end
                        r_durum <= TAMAM;
                    end
                end
                TAMAM: begin
                    r_bb_bitti <= ~r_sahip;
                    r_vb_bitti <= r_sahip;
                    r_durum    <= BOS;
                end
                default: begin
                    r_durum <= BOS;
                end
            endcase
        end
    end

    assign bb_kabul_o         = r_bb_kabul;
    assign vb_kabul_o         = r_vb_kabul;
    assign bb_bitti_o         = r_bb_bitti;
    assign vb_bitti_o         = r_vb_bitti;
    assign okunan_obek_o      = r_okunan;
    assign anabellege_istek_o = r_istek;
    assign oku_o              = r_oku;
    assign yaz_o              = r_yaz;
    assign oku_adres_o        = r_adres;
    assign yaz_adres_o        = r_adres;
    assign yaz_veri_obegi_o   = r_obek;

endmodule
